// File: rtl/imem_loader.sv
// Instruction-memory loader: assembles a big-endian byte stream into 32-bit
// words and writes up to 16 of them from address 0 while holding the CPU off.
module imem_loader (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [4:0]  word_count,
  input  logic        abort,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        wr_en,
  output logic [5:0]  wr_addr,
  output logic [31:0] wr_data,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [4:0]  count_q, count_d;
  logic [3:0]  index_q, index_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  // Only the first three bytes need storage; the fourth goes straight to wr_data.
  logic [23:0] asm_q, asm_d;
  logic [5:0]  wr_addr_q, wr_addr_d;
  logic [31:0] wr_data_q, wr_data_d;

  logic       byte_take_s;
  logic       last_word_s;
  logic [4:0] eff_count_s;

  assign eff_count_s = ((word_count == 5'd0) || (word_count > 5'd16)) ? 5'd16 : word_count;
  assign last_word_s = ({1'b0, index_q} == (count_q - 5'd1));
  assign byte_take_s = (state_q == LOAD) && in_valid && !abort;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d = LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      LOAD: begin
        if (abort) begin
          state_d = IDLE;
        end else if (byte_take_s && (byte_cnt_q == 2'd3)) begin
          state_d = WRITE;
        end else begin
          state_d = LOAD;
        end
      end
      WRITE: begin
        if (abort) begin
          state_d = IDLE;
        end else if (last_word_s) begin
          state_d = DONE;
        end else begin
          state_d = LOAD;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    wr_en    = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
      end
      LOAD: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
      WRITE: begin
        wr_en = 1'b1;
        busy  = 1'b1;
      end
      DONE: begin
        done = 1'b1;
        busy = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  // Word address/data are captured with the 4th byte so they are valid
  // throughout WRITE and keep the last written values afterwards.
  always_comb begin
    count_d    = count_q;
    index_d    = index_q;
    byte_cnt_d = byte_cnt_q;
    asm_d      = asm_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          count_d    = eff_count_s;
          index_d    = 4'd0;
          byte_cnt_d = 2'd0;
          asm_d      = 24'd0;
        end else begin
          count_d = count_q;
        end
      end
      LOAD: begin
        if (abort) begin
          byte_cnt_d = 2'd0;
          asm_d      = 24'd0;
        end else if (byte_take_s) begin
          asm_d      = {asm_q[15:0], in_data};
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            wr_addr_d = {index_q, 2'b00};
            wr_data_d = {asm_q, in_data};
          end else begin
            wr_addr_d = wr_addr_q;
          end
        end else begin
          asm_d = asm_q;
        end
      end
      WRITE: begin
        if (!abort && !last_word_s) begin
          index_d    = index_q + 4'd1;
          byte_cnt_d = 2'd0;
          asm_d      = 24'd0;
        end else begin
          index_d = index_q;
        end
      end
      DONE:    index_d = index_q;
      default: index_d = index_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q    <= 5'd0;
      index_q    <= 4'd0;
      byte_cnt_q <= 2'd0;
      asm_q      <= 24'd0;
      wr_addr_q  <= 6'd0;
      wr_data_q  <= 32'd0;
    end else begin
      count_q    <= count_d;
      index_q    <= index_d;
      byte_cnt_q <= byte_cnt_d;
      asm_q      <= asm_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
    end
  end

  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;

endmodule
